// File: rtl/fpadd_ctrl_if.sv
// rtl/fpadd_ctrl_if.sv - operand/result handshake bundle for fpadd_ctrl
interface fpadd_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, ovf, busy
  );
endinterface

// File: rtl/fpadd_ctrl.sv
// rtl/fpadd_ctrl.sv - multi-cycle binary32 adder: align, add, iterative normalize
// Optional FPADD_SPECIAL_EN: inf/NaN operands bypass straight to OUT with IEEE special results.
module fpadd_ctrl (
  input  logic         clk,
  input  logic         reset,
  fpadd_ctrl_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sign;
  logic        r_sub;
  logic [7:0]  r_exp;
  logic [23:0] r_big_m;
  logic [23:0] r_small_m;
  logic [24:0] r_sum;
  logic [31:0] r_result;
  logic        r_ovf;

  logic        w_alessb;
  logic [31:0] w_big;
  logic [31:0] w_small;
  logic [23:0] w_big_m;
  logic [23:0] w_small_m;
  logic [23:0] w_small_sh;
  logic [7:0]  w_shamt;
  logic        w_sat;
  logic        w_special;
  logic [31:0] w_special_res;

  // Magnitude compare on {exp,frac} guarantees e_big >= e_small, so shamt never wraps.
  assign w_alessb   = r_a[30:0] < r_b[30:0];
  assign w_big      = w_alessb ? r_b : r_a;
  assign w_small    = w_alessb ? r_a : r_b;
  assign w_big_m    = (w_big[30:23] == 8'd0)   ? 24'd0 : {1'b1, w_big[22:0]};
  assign w_small_m  = (w_small[30:23] == 8'd0) ? 24'd0 : {1'b1, w_small[22:0]};
  assign w_shamt    = w_big[30:23] - w_small[30:23];
  assign w_sat      = w_shamt[7] | w_shamt[6] | w_shamt[5] | (w_shamt[4] & w_shamt[3]);
  assign w_small_sh = w_sat ? 24'd0 : (w_small_m >> w_shamt[4:0]);

`ifdef FPADD_SPECIAL_EN
  logic w_a_max;
  logic w_b_max;
  logic w_nan;

  assign w_a_max   = bus.a[30:23] == 8'hFF;
  assign w_b_max   = bus.b[30:23] == 8'hFF;
  assign w_nan     = (w_a_max && bus.a[22:0] != 23'd0) || (w_b_max && bus.b[22:0] != 23'd0) ||
                     (w_a_max && w_b_max && (bus.a[31] != bus.b[31]));
  assign w_special = w_a_max | w_b_max;
  assign w_special_res = w_nan ? 32'h7FC00000 : (w_a_max ? bus.a : bus.b);
`else
  assign w_special     = 1'b0;
  assign w_special_res = 32'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_sign    <= 1'b0;
      r_sub     <= 1'b0;
      r_exp     <= 8'd0;
      r_big_m   <= 24'd0;
      r_small_m <= 24'd0;
      r_sum     <= 25'd0;
      r_result  <= 32'd0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_ovf <= 1'b0;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= S_OUT;
            end else begin
              r_state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          r_exp     <= w_big[30:23];
          r_sign    <= w_big[31];
          r_sub     <= w_big[31] ^ w_small[31];
          r_big_m   <= w_big_m;
          r_small_m <= w_small_sh;
          r_state   <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_big_m} - {1'b0, r_small_m})
                           : ({1'b0, r_big_m} + {1'b0, r_small_m});
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum == 25'd0) begin
            r_result <= 32'd0;
            r_state  <= S_OUT;
          end else if (r_sum[24]) begin
            if (r_exp >= 8'd254) begin
              r_result <= {r_sign, 8'hFF, 23'd0};
              r_ovf    <= 1'b1;
            end else begin
              r_result <= {r_sign, r_exp + 8'd1, r_sum[23:1]};
            end
            r_state <= S_OUT;
          end else if (r_sum[23]) begin
            r_result <= {r_sign, r_exp, r_sum[22:0]};
            r_state  <= S_OUT;
          end else if (r_exp <= 8'd1) begin
            r_result <= 32'd0;
            r_state  <= S_OUT;
          end else begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_fpadd_ctrl.sv
// tb/tb_fpadd_ctrl.sv - directed self-checking bench for fpadd_ctrl against an arithmetic model
`timescale 1ns/1ps
module tb_fpadd_ctrl;
  logic clk = 1'b0;
  logic reset;
  fpadd_ctrl_if fif();

  fpadd_ctrl dut (.clk(clk), .reset(reset), .bus(fif));

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_res  = 32'd0;
  logic        exp_ovf  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Reference: real-valued semantics on integer mantissas, latency = 3 + left shifts.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output int lat);
    logic [31:0] big, sml;
    int eb, es, sh;
    longint mb, ms, sum;
    o = 1'b0;
    lat = 3;
`ifdef FPADD_SPECIAL_EN
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      lat = 0;
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0) ||
          (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]))
        r = 32'h7FC00000;
      else
        r = (a[30:23] == 8'hFF) ? a : b;
      return;
    end
`endif
    if (a[30:0] < b[30:0]) begin big = b; sml = a; end
    else begin big = a; sml = b; end
    eb = int'(big[30:23]);
    es = int'(sml[30:23]);
    mb = (eb == 0) ? 0 : 64'h800000 + longint'(big[22:0]);
    ms = (es == 0) ? 0 : 64'h800000 + longint'(sml[22:0]);
    sh = eb - es;
    ms = (sh >= 24) ? 0 : (ms >> sh);
    sum = (big[31] != sml[31]) ? mb - ms : mb + ms;
    if (sum == 0) begin
      r = 32'd0;
    end else if (sum >= 64'h1000000) begin
      eb = eb + 1;
      sum = sum / 2;
      if (eb >= 255) begin
        r = {big[31], 8'hFF, 23'd0};
        o = 1'b1;
      end else begin
        r = {big[31], 8'(eb), 23'(sum)};
      end
    end else begin
      while (sum < 64'h800000 && eb > 1) begin
        sum = sum * 2;
        eb = eb - 1;
        lat++;
      end
      r = (sum < 64'h800000) ? 32'd0 : {big[31], 8'(eb), 23'(sum)};
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready_vs_busy", {31'd0, fif.in_ready}, {31'd0, !fif.busy});
      if (fif.out_valid) begin
        chk("result", fif.result, exp_res);
        chk("ovf", {31'd0, fif.ovf}, {31'd0, exp_ovf});
        chk("in_ready_in_out", {31'd0, fif.in_ready}, 32'd0);
      end
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input logic want_ovf, input int want_lat,
                        input int hold, input bit overlap);
    logic [31:0] r;
    logic o;
    int lat, n;
    model(a, b, r, o, lat);
    chk({name, "_model_res"}, r, want);
    chk({name, "_model_ovf"}, {31'd0, o}, {31'd0, want_ovf});
    chk({name, "_model_lat"}, lat, want_lat);
    @(negedge clk);
    exp_res = r;
    exp_ovf = o;
    fif.a = a;
    fif.b = b;
    fif.in_valid = 1'b1;
    chk({name, "_ready"}, {31'd0, fif.in_ready}, 32'd1);
    @(posedge clk);
    #1 fif.in_valid = 1'b0;
    n = 0;
    while (!fif.out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk({name, "_latency"}, n, lat);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    fif.out_ready = 1'b1;
    if (overlap) begin
      fif.a = 32'h3F800000;
      fif.b = 32'h3F800000;
      fif.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    fif.out_ready = 1'b0;
    fif.in_valid = 1'b0;
    chk({name, "_done"}, {30'd0, fif.out_valid, fif.in_ready}, 32'd1);
    if (overlap) chk({name, "_no_accept_in_out"}, {31'd0, fif.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic o;
    int lat;
    fif.in_valid = 1'b0;
    fif.out_ready = 1'b0;
    fif.a = 32'd0;
    fif.b = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, fif.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, fif.out_valid}, 32'd0);
    chk("rst_result", fif.result, 32'd0);
    chk("rst_ovf", {31'd0, fif.ovf}, 32'd0);
    chk("rst_busy", {31'd0, fif.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 3, 0, 1'b0);
    run_op("sat_shamt30",  32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 3, 0, 1'b0);
    run_op("sat_shamt24",  32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 3, 0, 1'b0);
    run_op("shamt23",      32'h3F800000, 32'h34000000, 32'h3F800001, 1'b0, 3, 0, 1'b0);
    run_op("sub_k2",       32'h3F800000, 32'hBF400000, 32'h3E800000, 1'b0, 5, 0, 1'b0);
    run_op("cancel",       32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 3, 0, 1'b0);
    run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 3, 0, 1'b0);
    run_op("carry",        32'h40400000, 32'h3F800000, 32'h40800000, 1'b0, 3, 0, 1'b0);
    run_op("neg_big",      32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b0, 4, 0, 1'b0);
    run_op("zero_a",       32'h00000000, 32'h3F800000, 32'h3F800000, 1'b0, 3, 0, 1'b0);
    run_op("flush_exp1",   32'h00800000, 32'h80C00000, 32'h00000000, 1'b0, 3, 0, 1'b0);
    run_op("min_normal",   32'h01000000, 32'h81400000, 32'h80800000, 1'b0, 4, 0, 1'b0);
    run_op("hold10",       32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 3, 10, 1'b0);
    run_op("overlap",      32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 3, 0, 1'b1);
`ifdef FPADD_SPECIAL_EN
    run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 0, 0, 1'b0);
    run_op("inf_plus_one",  32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 0, 0, 1'b0);
    run_op("nan_in",        32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 0, 0, 1'b0);
`else
    run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h00000000, 1'b0, 3, 0, 1'b0);
    run_op("inf_plus_one",  32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 3, 0, 1'b0);
`endif

    // Abort 1.0 - 0.75 while it is still normalizing.
    model(32'h3F800000, 32'hBF400000, r, o, lat);
    @(negedge clk);
    exp_res = r;
    exp_ovf = o;
    fif.a = 32'h3F800000;
    fif.b = 32'hBF400000;
    fif.in_valid = 1'b1;
    @(posedge clk);
    #1 fif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, fif.out_valid}, 32'd0);
    chk("abort_busy", {31'd0, fif.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("post_abort_out_valid", {31'd0, fif.out_valid}, 32'd0);
      chk("post_abort_in_ready", {31'd0, fif.in_ready}, 32'd1);
    end

    run_op("after_abort", 32'h3F800000, 32'hBF400000, 32'h3E800000, 1'b0, 5, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
